mem_slave: RTL and testbench

- Memory-side responder for the single-clock valid/ready memory bus driven by the testbench BFM.
- Sits directly downstream of the bus interface and consumes its wr_rd/addr/wdata/valid.
- Returns ready and rdata on the same bus, plus a one-cycle read-data strobe.
- Holds a DEPTH x WIDTH storage array; every accepted transaction is followed by a fixed, parameterised wait-state interval.

---
 rtl/mem_slave_if.sv | 32 +++
 rtl/mem_slave.sv | 131 +++++++++++++
 tb/tb_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_slave_if.sv
// Valid/ready memory bus between a requesting master and mem_slave.
//   wr_rd     : 1 = write, 0 = read (master -> slave)
//   addr      : word address (master -> slave)
//   wdata     : write data (master -> slave)
//   valid     : request, held stable until accepted (master -> slave)
//   ready     : slave can accept; handshake on valid && ready (slave -> master)
//   rdata     : read data, held until the next read completes (slave -> master)
//   rdata_vld : one-cycle strobe, rdata updated by a completed read (slave -> master)
interface mem_slave_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  valid;
  logic                  ready;
  logic [WIDTH-1:0]      rdata;
  logic                  rdata_vld;

  modport master (
    output wr_rd, addr, wdata, valid,
    input  ready, rdata, rdata_vld
  );

  modport slave (
    input  wr_rd, addr, wdata, valid,
    output ready, rdata, rdata_vld
  );

endinterface

// File: rtl/mem_slave.sv
// Memory-side responder: DEPTH x WIDTH storage behind a valid/ready bus. Every accepted
// request is latched, then executed after WAIT_CYCLES wait states during which ready is low.
//   clk : bus clock, all logic on posedge
//   res : synchronous active-high reset (clears storage, aborts any pending request)
//   bus : mem_slave_if slave modport (wr_rd/addr/wdata/valid in, ready/rdata/rdata_vld out)
module mem_slave #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic        clk,
  input logic        res,
  mem_slave_if.slave bus
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  // Counter loads WAIT_CYCLES-1 so the request executes on the edge where it reads 0.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic                  state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rdata_vld_q, rdata_vld_d;
  logic                  req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0]      req_wdata_q, req_wdata_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];

  logic                  accept;
  logic                  exec;
  logic                  ex_we;
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic [WIDTH-1:0]      ex_wdata;
  logic                  ex_in_range;
  logic [WIDTH-1:0]      rd_word;

  // ready_q gates acceptance, so the first cycle out of reset accepts nothing.
  assign accept = (state_q == ST_IDLE) && ready_q && bus.valid;

  // With no wait states the request executes on its accept edge straight from the bus.
  assign ex_we    = (WAIT_CYCLES == 0) ? bus.wr_rd : req_we_q;
  assign ex_addr  = (WAIT_CYCLES == 0) ? bus.addr  : req_addr_q;
  assign ex_wdata = (WAIT_CYCLES == 0) ? bus.wdata : req_wdata_q;

  // Widened compare stays meaningful when DEPTH is a power of two.
  assign ex_in_range = {1'b0, ex_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign rd_word     = ex_in_range ? mem_q[ex_addr] : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    exec        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_we_d    = bus.wr_rd;
          req_addr_d  = bus.addr;
          req_wdata_d = bus.wdata;
          if (WAIT_CYCLES == 0) begin
            exec = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          exec    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (exec && ex_we && ex_in_range) begin
      mem_d[ex_addr] = ex_wdata;
    end
  end

  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    rdata_vld_d = exec && !ex_we;
    rdata_d     = (exec && !ex_we) ? rd_word : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = rdata_vld_q;

endmodule

// File: tb/tb_mem_slave.sv
// Randomized self-checking bench for mem_slave. Three instances share one clock:
//   k=0: DEPTH 64, WAIT_CYCLES 2;  k=1: DEPTH 64, WAIT_CYCLES 0;  k=2: DEPTH 48, WAIT_CYCLES 3.
// Expected values come from a plain array model of memory plus the fixed latency rule.
module tb_mem_slave;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 6;
  localparam int          NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          res_t   [NI];
  logic          valid_t [NI];
  logic          wr_rd_t [NI];
  logic [AW-1:0] addr_t  [NI];
  logic [W-1:0]  wdata_t [NI];
  logic          ready_s [NI];
  logic [W-1:0]  rdata_s [NI];
  logic          vld_s   [NI];

  mem_slave_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus0 ();
  mem_slave_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus1 ();
  mem_slave_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus2 ();

  assign bus0.valid = valid_t[0];
  assign bus0.wr_rd = wr_rd_t[0];
  assign bus0.addr  = addr_t[0];
  assign bus0.wdata = wdata_t[0];
  assign ready_s[0] = bus0.ready;
  assign rdata_s[0] = bus0.rdata;
  assign vld_s[0]   = bus0.rdata_vld;

  assign bus1.valid = valid_t[1];
  assign bus1.wr_rd = wr_rd_t[1];
  assign bus1.addr  = addr_t[1];
  assign bus1.wdata = wdata_t[1];
  assign ready_s[1] = bus1.ready;
  assign rdata_s[1] = bus1.rdata;
  assign vld_s[1]   = bus1.rdata_vld;

  assign bus2.valid = valid_t[2];
  assign bus2.wr_rd = wr_rd_t[2];
  assign bus2.addr  = addr_t[2];
  assign bus2.wdata = wdata_t[2];
  assign ready_s[2] = bus2.ready;
  assign rdata_s[2] = bus2.rdata;
  assign vld_s[2]   = bus2.rdata_vld;

  mem_slave #(.WIDTH(W), .DEPTH(64), .ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_wait2 (
    .clk (clk),
    .res (res_t[0]),
    .bus (bus0)
  );

  mem_slave #(.WIDTH(W), .DEPTH(64), .ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_wait0 (
    .clk (clk),
    .res (res_t[1]),
    .bus (bus1)
  );

  mem_slave #(.WIDTH(W), .DEPTH(48), .ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_np2 (
    .clk (clk),
    .res (res_t[2]),
    .bus (bus2)
  );

  logic [W-1:0] model   [NI][64];
  logic [W-1:0] last_rd [NI];
  int vectors    = 0;
  int miscompares = 0;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int depth_of(input int k);
    return (k == 2) ? 48 : 64;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model(input int k);
    for (int a = 0; a < 64; a++) model[k][a] = '0;
    last_rd[k] = '0;
  endtask

  task automatic do_reset(input int k, input int cycles);
    @(negedge clk);
    res_t[k]   = 1'b1;
    valid_t[k] = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_ready", 32'(ready_s[k]), 32'd0);
      check("rst_rdata", 32'(rdata_s[k]), 32'd0);
      check("rst_vld", 32'(vld_s[k]), 32'd0);
    end
    res_t[k] = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(ready_s[k]), 32'd1);
    clear_model(k);
  endtask

  // One transaction; while busy the bus carries a conflicting write (ga/gd) that must be ignored.
  task automatic txn(input int k, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d,
                     input logic [AW-1:0] ga, input logic [W-1:0] gd);
    int n;
    int wc;
    wc = wait_of(k);
    @(negedge clk);
    valid_t[k] = 1'b1;
    wr_rd_t[k] = we;
    addr_t[k]  = a;
    wdata_t[k] = d;
    n = 0;
    while (!ready_s[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s[k]) begin
      check("accept_timeout", 32'd0, 32'd1);
      valid_t[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (we) begin
      if (int'(a) < depth_of(k)) model[k][a] = d;
    end else begin
      last_rd[k] = (int'(a) < depth_of(k)) ? model[k][a] : '0;
    end
    if (wc > 0) begin
      valid_t[k] = 1'b1;
      wr_rd_t[k] = 1'b1;
      addr_t[k]  = ga;
      wdata_t[k] = gd;
    end else begin
      valid_t[k] = 1'b0;
    end
    for (int j = 0; j <= wc; j++) begin
      @(negedge clk);
      if (j < wc) begin
        check("busy_ready", 32'(ready_s[k]), 32'd0);
        check("busy_vld", 32'(vld_s[k]), 32'd0);
      end else begin
        valid_t[k] = 1'b0;
        check("done_ready", 32'(ready_s[k]), 32'd1);
        check("done_vld", 32'(vld_s[k]), 32'(!we));
        check("rdata", 32'(rdata_s[k]), 32'(last_rd[k]));
      end
    end
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [W-1:0] d);
    txn(k, 1'b1, a, d, AW'($urandom), W'($urandom));
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    txn(k, 1'b0, a, W'($urandom), AW'($urandom), W'($urandom));
  endtask

  task automatic reset_mid_wait();
    int n;
    @(negedge clk);
    valid_t[0] = 1'b1;
    wr_rd_t[0] = 1'b1;
    addr_t[0]  = AW'(20);
    wdata_t[0] = 16'hBEEF;
    n = 0;
    while (!ready_s[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    valid_t[0] = 1'b0;
    res_t[0]   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_vld", 32'(vld_s[0]), 32'd0);
      check("abort_ready", 32'(ready_s[0]), 32'd0);
    end
    res_t[0] = 1'b0;
    @(negedge clk);
    check("abort_release_ready", 32'(ready_s[0]), 32'd1);
    check("abort_release_vld", 32'(vld_s[0]), 32'd0);
    clear_model(0);
    rd(0, AW'(20));
  endtask

  // Back-to-back write/read pairs with valid held high; zero-wait instance only.
  task automatic stream_wait0();
    bit           prev_rd;
    logic [W-1:0] prev_exp;
    logic [W-1:0] d;
    int           a;
    prev_rd  = 1'b0;
    prev_exp = '0;
    @(negedge clk);
    check("stream_idle_ready", 32'(ready_s[1]), 32'd1);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("stream_ready", 32'(ready_s[1]), 32'd1);
        check("stream_vld", 32'(vld_s[1]), 32'(prev_rd));
        if (prev_rd) check("stream_rdata", 32'(rdata_s[1]), 32'(prev_exp));
      end
      if (i < 8) begin
        a = 10 + i / 2;
        valid_t[1] = 1'b1;
        addr_t[1]  = AW'(a);
        if (i % 2 == 0) begin
          d          = W'($urandom);
          wr_rd_t[1] = 1'b1;
          wdata_t[1] = d;
          model[1][a] = d;
          prev_rd    = 1'b0;
        end else begin
          wr_rd_t[1] = 1'b0;
          wdata_t[1] = W'($urandom);
          prev_exp   = model[1][a];
          last_rd[1] = prev_exp;
          prev_rd    = 1'b1;
        end
        @(negedge clk);
      end else begin
        valid_t[1] = 1'b0;
      end
    end
  endtask

  task automatic random_phase(input int k, input int count);
    logic [AW-1:0] a;
    for (int i = 0; i < count; i++) begin
      if (k == 2 || $urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 63));
      else a = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr(k, a, W'($urandom));
      else rd(k, a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      res_t[k]   = 1'b1;
      valid_t[k] = 1'b0;
      wr_rd_t[k] = 1'b0;
      addr_t[k]  = '0;
      wdata_t[k] = '0;
      clear_model(k);
    end

    // Wait-2 instance: reset, full clear, directed cases, abort, random.
    do_reset(0, 3);
    for (int a = 0; a < 64; a++) rd(0, AW'(a));
    wr(0, AW'(5), 16'hA5A5);
    rd(0, AW'(5));
    wr(0, AW'(63), 16'h1234);
    wr(0, AW'(0), 16'h4321);
    rd(0, AW'(63));
    rd(0, AW'(0));
    txn(0, 1'b1, AW'(7), 16'h0F0F, AW'(8), 16'hFFFF);
    rd(0, AW'(7));
    rd(0, AW'(8));
    reset_mid_wait();
    random_phase(0, 60);

    // Zero-wait instance: streaming then random.
    do_reset(1, 3);
    stream_wait0();
    random_phase(1, 60);

    // Non-power-of-two depth: out-of-range writes dropped, reads return zero.
    do_reset(2, 2);
    wr(2, AW'(50), 16'hDEAD);
    rd(2, AW'(50));
    rd(2, AW'(2));
    wr(2, AW'(47), 16'h7777);
    rd(2, AW'(47));
    random_phase(2, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
